// File: rtl/svm_pkg.sv
// Shared types and sizing for the SVM classifier and its parameter loader.
package svm_pkg;

  localparam int unsigned W       = 16;
  localparam int unsigned DIMS    = 21;
  localparam int unsigned CLASSES = 3;
  localparam int unsigned NWORDS  = DIMS * CLASSES + CLASSES;

  typedef logic [W-1:0]                 T;
  typedef logic [$clog2(CLASSES)-1:0]   cls_idx_t;
  typedef logic [$clog2(DIMS)-1:0]      dim_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } ld_state_e;

endpackage

// File: rtl/svm_param_loader.sv
// Serial weight/bias loader: assembles a word stream in a shadow buffer and
// commits it atomically to the arrays driving the classifier.
module svm_param_loader
  import svm_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           start_i,
  input  logic                           abort_i,
  input  T                               wdata_i,
  input  logic                           wvalid_i,
  output logic                           wready_o,
  output T [DIMS-1:0][CLASSES-1:0]       feats_o,
  output T [CLASSES-1:0]                 biases_o,
  output logic                           params_valid_o,
  output logic                           busy_o,
  output logic                           done_o
);

  ld_state_e                   r_state;
  ld_state_e                   w_next;

  dim_idx_t                    r_d;
  cls_idx_t                    r_c;
  cls_idx_t                    r_bc;
  logic                        r_bias_phase;

  T [DIMS-1:0][CLASSES-1:0]    r_sh_feats;
  T [CLASSES-1:0]              r_sh_biases;
  T [DIMS-1:0][CLASSES-1:0]    r_feats;
  T [CLASSES-1:0]              r_biases;
  logic                        r_params_valid;
  logic                        r_done;

  logic                        w_accept;
  logic                        w_col_end;
  logic                        w_row_end;
  logic                        w_last;

  assign w_accept  = wvalid_i & wready_o;
  assign w_col_end = (r_c == cls_idx_t'(CLASSES - 1));
  assign w_row_end = (r_d == dim_idx_t'(DIMS - 1));
  assign w_last    = r_bias_phase & (r_bc == cls_idx_t'(CLASSES - 1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (start_i) w_next = LOAD;
      LOAD: begin
        if (abort_i)                 w_next = IDLE;
        else if (w_accept && w_last) w_next = COMMIT;
      end
      COMMIT: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    wready_o = 1'b0;
    busy_o   = (r_state != IDLE);
    if (r_state == LOAD) wready_o = !abort_i;
  end

  // Row/column walk over the weight matrix, then a separate bias index,
  // so the word position never needs a divide by CLASSES.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_d          <= '0;
      r_c          <= '0;
      r_bc         <= '0;
      r_bias_phase <= 1'b0;
      r_sh_feats   <= '0;
      r_sh_biases  <= '0;
    end else if (r_state == IDLE && start_i) begin
      r_d          <= '0;
      r_c          <= '0;
      r_bc         <= '0;
      r_bias_phase <= 1'b0;
    end else if (w_accept) begin
      if (!r_bias_phase) begin
        r_sh_feats[r_d][r_c] <= wdata_i;
        if (w_col_end) begin
          r_c <= '0;
          if (w_row_end) r_bias_phase <= 1'b1;
          else           r_d          <= r_d + 1'b1;
        end else begin
          r_c <= r_c + 1'b1;
        end
      end else begin
        r_sh_biases[r_bc] <= wdata_i;
        r_bc              <= r_bc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_feats        <= '0;
      r_biases       <= '0;
      r_params_valid <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_done <= (r_state == COMMIT);
      if (r_state == COMMIT) begin
        r_feats        <= r_sh_feats;
        r_biases       <= r_sh_biases;
        r_params_valid <= 1'b1;
      end
    end
  end

  assign feats_o        = r_feats;
  assign biases_o       = r_biases;
  assign params_valid_o = r_params_valid;
  assign done_o         = r_done;

endmodule

// File: tb/tb_svm_param_loader.sv
// Self-checking bench for svm_param_loader against a word-stream reference model.
module tb_svm_param_loader;
  import svm_pkg::*;

  logic                      clk_i = 1'b0;
  logic                      rstn_i;
  logic                      start_i;
  logic                      abort_i;
  T                          wdata_i;
  logic                      wvalid_i;
  logic                      wready_o;
  T [DIMS-1:0][CLASSES-1:0]  feats_o;
  T [CLASSES-1:0]            biases_o;
  logic                      params_valid_o;
  logic                      busy_o;
  logic                      done_o;

  svm_param_loader dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .wdata_i        (wdata_i),
    .wvalid_i       (wvalid_i),
    .wready_o       (wready_o),
    .feats_o        (feats_o),
    .biases_o       (biases_o),
    .params_valid_o (params_valid_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the committed parameter set, derived from word order k.
  T   words [NWORDS];
  T   exp_f [DIMS][CLASSES];
  T   exp_b [CLASSES];
  bit exp_pv;

  typedef struct {
    string nm;
    int    d;     // -1 selects the bias array
    int    c;
    int    exp;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_reset();
    for (int d = 0; d < DIMS; d++)
      for (int c = 0; c < CLASSES; c++) exp_f[d][c] = '0;
    for (int c = 0; c < CLASSES; c++) exp_b[c] = '0;
    exp_pv = 1'b0;
  endtask

  task automatic model_commit();
    for (int k = 0; k < NWORDS; k++) begin
      if (k < DIMS * CLASSES) exp_f[k / CLASSES][k % CLASSES] = words[k];
      else                    exp_b[k - DIMS * CLASSES]       = words[k];
    end
    exp_pv = 1'b1;
  endtask

  task automatic check_active(input string tag);
    for (int d = 0; d < DIMS; d++)
      for (int c = 0; c < CLASSES; c++)
        chk($sformatf("%s_feats[%0d][%0d]", tag, d, c), feats_o[d][c], exp_f[d][c]);
    for (int c = 0; c < CLASSES; c++)
      chk($sformatf("%s_biases[%0d]", tag, c), biases_o[c], exp_b[c]);
    chk({tag, "_params_valid"}, params_valid_o, exp_pv);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_feats_zero"},   (feats_o != '0),  0);
    chk({tag, "_biases_zero"},  (biases_o != '0), 0);
    chk({tag, "_params_valid"}, params_valid_o,   0);
    chk({tag, "_wready"},       wready_o,         0);
    chk({tag, "_busy"},         busy_o,           0);
    chk({tag, "_done"},         done_o,           0);
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].d < 0)
        chk({tag, "_", tbl[i].nm}, biases_o[tbl[i].c], tbl[i].exp);
      else
        chk({tag, "_", tbl[i].nm}, feats_o[tbl[i].d][tbl[i].c], tbl[i].exp);
    end
  endtask

  // mode: 0 -> k+1, 1 -> 0xA5A5, 2 -> random. Negative *_at disables that event.
  task automatic do_load(input int mode, input bit rand_valid, input int abort_at,
                         input int start_at, input int reset_at, input bit start_abort,
                         input string tag);
    int acc    = 0;
    int cycles = 0;
    int dones  = 0;
    bit started_pulse = 1'b0;
    bit v, ab, st;
    for (int k = 0; k < NWORDS; k++) begin
      case (mode)
        0:       words[k] = T'(k + 1);
        1:       words[k] = 16'hA5A5;
        default: words[k] = T'($urandom);
      endcase
    end
    start_i  = 1'b1;
    abort_i  = start_abort;
    wvalid_i = 1'b0;
    cyc();
    start_i  = 1'b0;
    abort_i  = 1'b0;
    chk({tag, "_busy_after_start"}, busy_o, 1);
    while (acc < NWORDS) begin
      if (cycles >= 2000) begin
        chk({tag, "_load_timeout"}, acc, NWORDS);
        wvalid_i = 1'b0;
        return;
      end
      if (acc == reset_at) begin
        wvalid_i = 1'b1;
        wdata_i  = words[acc];
        #3 rstn_i = 1'b0;
        #1 model_reset();
        check_reset_state({tag, "_async_rst"});
        #2 rstn_i = 1'b1;
        wvalid_i = 1'b1;
        cyc();
        chk({tag, "_wready_after_rst"}, wready_o, 0);
        cyc();
        chk({tag, "_wready_idle_rst"}, wready_o, 0);
        chk({tag, "_busy_idle_rst"}, busy_o, 0);
        wvalid_i = 1'b0;
        return;
      end
      v  = rand_valid ? 1'($urandom_range(1)) : 1'b1;
      ab = (acc == abort_at);
      st = (acc == start_at) && !started_pulse;
      if (st) started_pulse = 1'b1;
      wvalid_i = v;
      wdata_i  = v ? words[acc] : T'($urandom);
      abort_i  = ab;
      start_i  = st;
      #2;
      chk({tag, "_wready_load"}, wready_o, !ab);
      cyc();
      cycles++;
      start_i = 1'b0;
      if (done_o) dones++;
      if (ab) begin
        abort_i  = 1'b0;
        wvalid_i = 1'b0;
        chk({tag, "_busy_after_abort"}, busy_o, 0);
        chk({tag, "_done_after_abort"}, done_o, 0);
        check_active({tag, "_abort_hold"});
        return;
      end
      if (v) acc++;
    end
    // COMMIT cycle: a word and an abort are both offered and must be ignored.
    wvalid_i = 1'b1;
    wdata_i  = 16'hDEAD;
    abort_i  = 1'b1;
    #2;
    chk({tag, "_wready_commit"}, wready_o, 0);
    chk({tag, "_busy_commit"}, busy_o, 1);
    chk({tag, "_done_commit"}, done_o, 0);
    chk({tag, "_done_during_load"}, dones, 0);
    check_active({tag, "_pre_commit"});
    cyc();
    wvalid_i = 1'b0;
    abort_i  = 1'b0;
    model_commit();
    chk({tag, "_done_pulse"}, done_o, 1);
    chk({tag, "_busy_post"}, busy_o, 0);
    check_active({tag, "_post_commit"});
    cyc();
    chk({tag, "_done_clear"}, done_o, 0);
  endtask

  initial begin
    tbl[0] = '{"f00", 0,  0, 1};
    tbl[1] = '{"f02", 0,  2, 3};
    tbl[2] = '{"f10", 1,  0, 4};
    tbl[3] = '{"f202", 20, 2, 63};
    tbl[4] = '{"b0", -1, 0, 64};
    tbl[5] = '{"b2", -1, 2, 66};

    rstn_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; wvalid_i = 1'b0; wdata_i = '0;
    model_reset();
    #3;
    check_reset_state("init");
    #4 rstn_i = 1'b1;
    cyc();
    chk("init_wready_idle", wready_o, 0);

    // Sequential k+1 load with back-to-back words.
    do_load(0, 1'b0, -1, -1, -1, 1'b0, "seq");
    check_table("seq_tbl");

    // Abort after 30 accepts keeps the previous set.
    do_load(2, 1'b0, 30, -1, -1, 1'b0, "abort30");
    check_table("abort30_tbl");
    do_load(1, 1'b0, -1, -1, -1, 1'b0, "a5");

    // Same k+1 load with a throttled valid.
    do_load(0, 1'b1, -1, -1, -1, 1'b0, "throttle");
    check_table("throttle_tbl");

    // Words offered while idle are refused.
    for (int i = 0; i < 5; i++) begin
      wvalid_i = 1'b1;
      wdata_i  = 16'hFFFF;
      abort_i  = (i == 2);
      #2;
      chk("idle_wready", wready_o, 0);
      chk("idle_busy", busy_o, 0);
      cyc();
    end
    wvalid_i = 1'b0;
    abort_i  = 1'b0;
    check_active("idle_hold");

    // A start pulse inside LOAD does not restart the word count.
    do_load(2, 1'b0, -1, 10, -1, 1'b0, "start_in_load");

    // Reset during load, then a full load recovers.
    do_load(2, 1'b0, -1, -1, 40, 1'b0, "rst40");
    do_load(2, 1'b1, -1, -1, -1, 1'b0, "post_rst");

    // Mid-simulation reset from IDLE with valid parameters loaded.
    #2 rstn_i = 1'b0;
    #1 model_reset();
    check_reset_state("mid_rst");
    #2 rstn_i = 1'b1;
    cyc();

    // start and abort together in IDLE: start wins.
    do_load(2, 1'b0, -1, -1, -1, 1'b1, "start_abort");

    for (int r = 0; r < 4; r++) begin
      do_load(2, 1'b1, (r % 2 == 0) ? int'($urandom_range(0, NWORDS - 1)) : -1,
              -1, -1, 1'b0, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
